// File: rtl/tc_pkg.sv
// Shared types and defaults for the serial two's-complement transmitter.
package tc_pkg;

    typedef enum logic {
        TC_IDLE  = 1'b0,
        TC_SHIFT = 1'b1
    } tc_state_e;

    localparam int TC_WIDTH_DEF = 8;

endpackage

// File: rtl/tc_negate_bit.sv
// One-bit serial complement cell: passes bits up to and including the first 1,
// then inverts. clr restarts the rule on the bit presented in the same cycle.
module tc_negate_bit (
    input  logic t_clk,
    input  logic r,
    input  logic clr,
    input  logic en,
    input  logic b,
    output logic y
);

    logic seen;
    logic seen_eff;

    assign seen_eff = seen & ~clr;
    assign y        = seen_eff ? ~b : b;

    always_ff @(posedge t_clk or posedge r) begin
        if (r)
            seen <= 1'b0;
        else if (en)
            seen <= seen_eff | b;
        else if (clr)
            seen <= 1'b0;
    end

endmodule

// File: rtl/tc_serial_tx.sv
// LSB-first bit-serial transmitter with valid/ready word input.
// Define TC_TX_NEGATE_EN to add the per-word in-line negate (neg port).
module tc_serial_tx
    import tc_pkg::*;
#(
    parameter int WIDTH = TC_WIDTH_DEF
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
`ifdef TC_TX_NEGATE_EN
    input  logic             neg,
`endif
    output logic             rdy,
    output logic             sout,
    output logic             sval,
    output logic             sstart,
    output logic             sdone
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    tc_state_e        state;
    logic [CW-1:0]    cnt;
    // Holds only the bits still to be emitted; bit 0 goes out straight from din.
    logic [WIDTH-2:0] sreg;
    logic             last;
    logic             accept;
    logic             advance;
    logic             raw_bit;
    logic             bit_out;

    assign last    = (cnt == CW'(WIDTH - 1));
    assign rdy     = (state == TC_IDLE) || (state == TC_SHIFT && last);
    assign accept  = load && rdy;
    assign advance = (state == TC_SHIFT) && !last;
    assign raw_bit = accept ? din[0] : sreg[0];

`ifdef TC_TX_NEGATE_EN
    logic neg_q;
    logic neg_bit;

    tc_negate_bit u_neg (
        .t_clk (t_clk),
        .r     (r),
        .clr   (accept),
        .en    (accept || advance),
        .b     (raw_bit),
        .y     (neg_bit)
    );

    assign bit_out = (accept ? neg : neg_q) ? neg_bit : raw_bit;

    always_ff @(posedge t_clk or posedge r) begin
        if (r)
            neg_q <= 1'b0;
        else if (accept)
            neg_q <= neg;
    end
`else
    assign bit_out = raw_bit;
`endif

    always_ff @(posedge t_clk or posedge r) begin
        if (r) begin
            state  <= TC_IDLE;
            cnt    <= '0;
            sreg   <= '0;
            sout   <= 1'b0;
            sval   <= 1'b0;
            sstart <= 1'b0;
            sdone  <= 1'b0;
        end else if (accept) begin
            state  <= TC_SHIFT;
            cnt    <= '0;
            sreg   <= din[WIDTH-1:1];
            sout   <= bit_out;
            sval   <= 1'b1;
            sstart <= 1'b1;
            sdone  <= 1'b0;
        end else if (advance) begin
            cnt    <= cnt + CW'(1);
            sreg   <= sreg >> 1;
            sout   <= bit_out;
            sstart <= 1'b0;
            sdone  <= (cnt == CW'(WIDTH - 2));
        end else begin
            state  <= TC_IDLE;
            sout   <= 1'b0;
            sval   <= 1'b0;
            sstart <= 1'b0;
            sdone  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tc_serial_tx.sv
// Directed bench for tc_serial_tx (WIDTH=8); negate vectors run with TC_TX_NEGATE_EN.
module tb_tc_serial_tx;

    logic       t_clk = 1'b0;
    logic       r     = 1'b1;
    logic       load  = 1'b0;
    logic [7:0] din   = 8'h00;
`ifdef TC_TX_NEGATE_EN
    logic       neg   = 1'b0;
`endif
    logic       rdy, sout, sval, sstart, sdone;

    int checks = 0;
    int errors = 0;

    always #5 t_clk = ~t_clk;

    tc_serial_tx #(.WIDTH(8)) dut (
        .t_clk  (t_clk),
        .r      (r),
        .load   (load),
        .din    (din),
`ifdef TC_TX_NEGATE_EN
        .neg    (neg),
`endif
        .rdy    (rdy),
        .sout   (sout),
        .sval   (sval),
        .sstart (sstart),
        .sdone  (sdone)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one word, then check all 8 bit cycles and the idle cycle after.
    task automatic send_word(input string tag, input logic [7:0] w, input logic ng,
                             input logic [7:0] expw);
        @(negedge t_clk);
        check({tag, " rdy"}, rdy, 1);
        load = 1'b1;
        din  = w;
`ifdef TC_TX_NEGATE_EN
        neg  = ng;
`else
        if (ng) $display("note: neg ignored in this build");
`endif
        @(posedge t_clk);
        #1 load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge t_clk);
            check($sformatf("%s sout%0d", tag, i), sout, expw[i]);
            check($sformatf("%s sval%0d", tag, i), sval, 1);
            check($sformatf("%s sstart%0d", tag, i), sstart, (i == 0) ? 1 : 0);
            check($sformatf("%s sdone%0d", tag, i), sdone, (i == 7) ? 1 : 0);
        end
        @(negedge t_clk);
        check({tag, " idle sval"}, sval, 0);
        check({tag, " idle rdy"}, rdy, 1);
    endtask

    initial begin
        logic [15:0] stream;
        logic [7:0]  w;

        // Reset state
        #2;
        check("rst sout", sout, 0);
        check("rst sval", sval, 0);
        check("rst sstart", sstart, 0);
        check("rst sdone", sdone, 0);
        check("rst rdy", rdy, 1);
        @(negedge t_clk);
        r = 1'b0;

        // Reset mid-word: after bit 3 of A5
        @(negedge t_clk);
        load = 1'b1;
        din  = 8'hA5;
        @(posedge t_clk);
        #1 load = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge t_clk);
        check("mid bit3", sout, 0);
        check("mid sval", sval, 1);
        #1 r = 1'b1;
        #1;
        check("mid rst sval", sval, 0);
        check("mid rst sout", sout, 0);
        check("mid rst sstart", sstart, 0);
        check("mid rst sdone", sdone, 0);
        @(negedge t_clk);
        r = 1'b0;
        @(negedge t_clk);
        check("post rst rdy", rdy, 1);
        check("post rst sval", sval, 0);
        send_word("w01", 8'h01, 1'b0, 8'h01);

        // Single word
        send_word("wA5", 8'hA5, 1'b0, 8'hA5);

        // Back-to-back 3C then FF with load held
        stream = 16'hFF3C;
        @(negedge t_clk);
        load = 1'b1;
        din  = 8'h3C;
        @(posedge t_clk);
        for (int j = 1; j <= 16; j++) begin
            @(negedge t_clk);
            w = stream[j-1 +: 8];
            check($sformatf("b2b sout%0d", j), sout, w[0]);
            check($sformatf("b2b sval%0d", j), sval, 1);
            check($sformatf("b2b sstart%0d", j), sstart, (j == 1 || j == 9) ? 1 : 0);
            check($sformatf("b2b sdone%0d", j), sdone, (j == 8 || j == 16) ? 1 : 0);
            check($sformatf("b2b rdy%0d", j), rdy, (j == 8 || j == 16) ? 1 : 0);
            if (j == 8)  din  = 8'hFF;
            if (j == 16) load = 1'b0;
        end
        @(negedge t_clk);
        check("b2b idle sval", sval, 0);

        // Load while busy is ignored
        @(negedge t_clk);
        load = 1'b1;
        din  = 8'h0F;
        @(posedge t_clk);
        #1 load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge t_clk);
            check($sformatf("busy sout%0d", i), sout, (i < 4) ? 1 : 0);
            check($sformatf("busy sstart%0d", i), sstart, (i == 0) ? 1 : 0);
            if (i == 2) begin
                load = 1'b1;
                din  = 8'h55;
            end else begin
                load = 1'b0;
            end
        end
        @(negedge t_clk);
        check("busy idle sval", sval, 0);
        @(negedge t_clk);
        check("busy idle2 sval", sval, 0);

`ifdef TC_TX_NEGATE_EN
        send_word("neg06", 8'h06, 1'b1, 8'hFA);
        send_word("neg00", 8'h00, 1'b1, 8'h00);
        send_word("neg80", 8'h80, 1'b1, 8'h80);
        send_word("pos06", 8'h06, 1'b0, 8'h06);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tc_serial_tx.md
# tc_serial_tx

Bit-serial transmitter feeding the serial two's-complement datapath. It accepts a parallel WIDTH-bit word with a valid/ready handshake and shifts it out LSB-first, one bit per t_clk. A start strobe marks bit 0 so the downstream serial complementer can restart per word. It can optionally negate the word in-line, using the copy-until-first-one rule.

## Interface
- WIDTH, 8: word width in bits; minimum 2.
- t_clk  in  1  single clock, rising-edge.
- r  in  1  reset, asynchronous, active-high.
- load  in  1  word valid; accepted on a rising edge where load && rdy.
- din  in  WIDTH  word to transmit, two's complement.
- neg  in  1  negate this word, sampled with din. Present only with TC_TX_NEGATE_EN.
- rdy  out  1  transmitter can accept a word this cycle.
- sout  out  1  serial data, LSB first.
- sval  out  1  sout carries a valid bit.
- sstart  out  1  high while bit 0 is on sout; usable as the downstream per-word reset.
- sdone  out  1  high while bit WIDTH-1 is on sout.

## Operation
- FSM states:
  - IDLE: rdy=1, sval=0.
  - SHIFT: sout carries bit cnt of the shift register.
- IDLE to SHIFT on accept: capture din into the shift register and set cnt=0.
- In SHIFT:
  - cnt increments each cycle and the shift register moves right by 1.
  - At cnt=WIDTH-1 with no accept, go to IDLE.
  - At cnt=WIDTH-1 with an accept, reload and set cnt=0 without a gap.
- rdy = (state==IDLE) || (state==SHIFT && cnt==WIDTH-1). It is combinational from registered state and does not depend on load.
- Counter width is $clog2(WIDTH). cnt never exceeds WIDTH-1 and never wraps inside a word.
- All of sout, sval, sstart and sdone are registered.
- load while rdy=0 is ignored. din is not captured and no error is flagged.
- Asynchronous reset:
  - Forces state=IDLE, cnt=0, shift register=0, sout=0, sval=0, sstart=0, sdone=0, seen-one flag=0.
  - rdy=1 after reset.
  - Reset mid-word abandons the word; no further bits of it are emitted.

## Timing
- Accept on edge k: bit 0 is on sout during cycle k+1 with sval=1 and sstart=1.
- Bit i is on sout during cycle k+1+i. Bit WIDTH-1 is on sout during cycle k+WIDTH with sdone=1.
- Latency from accept to first bit: 1 cycle.
- Throughput: one word per WIDTH cycles when load is held high. sval stays 1 continuously, and sstart and sdone repeat every WIDTH cycles.
- Single word, no follow-on: sval drops in cycle k+WIDTH+1.
- sstart and sdone are both high only if WIDTH=1, which is disallowed.

## Configuration
- TC_TX_NEGATE_EN defined:
  - The neg port exists and is captured with din on accept.
  - When captured neg=1, each emitted bit = seen ? ~b : b, where b is the raw shift-register bit.
  - seen is set after the first emitted raw 1 and cleared on every accept.
  - The result is the serial two's complement (mod 2^WIDTH). Negating 0 gives 0, and negating the most-negative value gives itself.
- TC_TX_NEGATE_EN undefined: no neg port, no seen flag, and sout = raw shift-register LSB.

## Structure
- Package tc_pkg holds:
  - the state enum (TC_IDLE, TC_SHIFT)
  - TC_WIDTH_DEF = 8
- Sub-module tc_negate_bit (used only under TC_TX_NEGATE_EN):
  - one-bit serial complement cell with inputs t_clk, r, clr, en, b and output y
  - holds the seen flag
  - same behaviour as the datapath's serial complementer, so both sides share one proven cell

## Test plan
- Reset check: assert r mid-word (after bit 3 of 8'hA5). Outputs go to 0 immediately, and rdy=1 after release. The next load of 8'h01 emits 1,0,0,0,0,0,0,0.
- Single word: load 8'hA5. sout = 1,0,1,0,0,1,0,1 over 8 cycles, with sstart on the first cycle and sdone on the last. Then sval=0.
- Back-to-back: hold load with 8'h3C then 8'hFF. This gives 16 contiguous sval cycles with sstart at cycles 1 and 9 and rdy high only on cycles 8 and 16. The stream is 0,0,1,1,1,1,0,0 then 1×8.
- Load while busy: pulse load with 8'h55 during cycle 3 of 8'h0F. It is ignored; the stream stays 1,1,1,1,0,0,0,0 and then goes IDLE.
- Negate (TC_TX_NEGATE_EN): load 8'h06 with neg=1. The stream is 0,1,0,1,1,1,1,1 (= 8'hFA).
- Negate boundaries (TC_TX_NEGATE_EN): 8'h00 with neg=1 gives 0×8, and 8'h80 with neg=1 gives 8'h80.
